dmux_1_to_8: RTL and testbench

Registered 1-to-8 demultiplexer. Routes a single data input to one of eight output lanes selected by a 3-bit select. All unselected lanes are driven to zero. Sits in the datapath wherever one source must be steered to one of eight sinks. The output is registered so downstream logic sees glitch-free, clock-aligned lanes.

---
 rtl/dmux_1_to_8_if.sv | 11 +
 rtl/dmux_1_to_8.sv | 30 +++
 tb/tb_dmux_1_to_8.sv | 90 +++++++++
 3 files changed

// File: rtl/dmux_1_to_8_if.sv
// Routing bus for the 1-to-8 demultiplexer: source data/select in, eight lanes out.
interface dmux_1_to_8_if #(
  parameter int WIDTH = 1
);
  logic [WIDTH-1:0]   i;
  logic [2:0]         sel;
  logic [8*WIDTH-1:0] y;

  modport master (output i, output sel, input y);
  modport slave  (input i, input sel, output y);
endinterface

// File: rtl/dmux_1_to_8.sv
// Registered 1-to-8 demultiplexer: steers i onto lane sel, zeroes every other lane.
module dmux_1_to_8 #(
  parameter int WIDTH = 1
) (
  input  logic           clk,
  input  logic           rst,
  dmux_1_to_8_if.slave   bus
);

  logic [8*WIDTH-1:0] y_q;

  function automatic logic [8*WIDTH-1:0] route(input logic [WIDTH-1:0] d,
                                               input logic [2:0]       s);
    logic [8*WIDTH-1:0] r;
    r = '0;
    for (int k = 0; k < 8; k++) begin
      if (s == 3'(k)) r[k*WIDTH +: WIDTH] = d;
    end
    return r;
  endfunction

  // stage p0: single output register, reset wins over routing
  always_ff @(posedge clk) begin
    if (rst) y_q <= '0;
    else     y_q <= route(bus.i, bus.sel);
  end

  assign bus.y = y_q;

endmodule

// File: tb/tb_dmux_1_to_8.sv
// Scoreboard bench for dmux_1_to_8 at WIDTH=1 and WIDTH=4, both DUTs stepped together.
module tb_dmux_1_to_8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  dmux_1_to_8_if #(.WIDTH(1)) bus1 ();
  dmux_1_to_8_if #(.WIDTH(4)) bus4 ();

  dmux_1_to_8 #(.WIDTH(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1.slave));
  dmux_1_to_8 #(.WIDTH(4)) dut4 (.clk(clk), .rst(rst), .bus(bus4.slave));

  int checks   = 0;
  int failures = 0;

  logic [7:0]  q1[$];
  logic [31:0] q4[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
    end
  endtask

  // Drive one cycle of stimulus, queue the expectation, then compare after the edge.
  task automatic step(input string tag, input logic r,
                      input logic i1, input logic [2:0] s1,
                      input logic [3:0] i4, input logic [2:0] s4);
    logic [7:0]  e1;
    logic [31:0] e4;
    rst      = r;
    bus1.i   = i1;
    bus1.sel = s1;
    bus4.i   = i4;
    bus4.sel = s4;
    e1 = r ? 8'h00  : (8'(i1) << s1);
    e4 = r ? 32'h0  : (32'(i4) << (4 * s4));
    q1.push_back(e1);
    q4.push_back(e4);
    @(posedge clk);
    #1;
    if (q1.size() == 0) chk({tag, "_q1empty"}, 32'd1, 32'd0);
    else chk({tag, "_w1"}, {24'h0, bus1.y}, {24'h0, q1.pop_front()});
    if (q4.size() == 0) chk({tag, "_q4empty"}, 32'd1, 32'd0);
    else chk({tag, "_w4"}, bus4.y, q4.pop_front());
  endtask

  initial begin
    rst = 1'b1; bus1.i = 1'b1; bus1.sel = 3'd5; bus4.i = 4'hA; bus4.sel = 3'd3;
    #2;
    // reset held two cycles with active data, then release
    step("rst0", 1'b1, 1'b1, 3'd5, 4'hA, 3'd3);
    step("rst1", 1'b1, 1'b1, 3'd5, 4'hA, 3'd3);
    step("rel",  1'b0, 1'b1, 3'd5, 4'hA, 3'd3);
    chk("rel_lit", {24'h0, bus1.y}, 32'h20);
    chk("w4_lit3", bus4.y, 32'h0000A000);
    step("w4s0", 1'b0, 1'b1, 3'd5, 4'hA, 3'd0);
    chk("w4_lit0", bus4.y, 32'h0000000A);
    // select sweep
    for (int s = 0; s < 8; s++) begin
      step($sformatf("sweep%0d", s), 1'b0, 1'b1, 3'(s), 4'(s + 1), 3'(7 - s));
      chk($sformatf("sweep_lit%0d", s), {24'h0, bus1.y}, 32'(1) << s);
    end
    // zero data
    step("z3", 1'b0, 1'b0, 3'd3, 4'h0, 3'd3);
    step("z7", 1'b0, 1'b0, 3'd7, 4'h0, 3'd7);
    chk("z7_lane3", {31'h0, bus1.y[3]}, 32'h0);
    chk("z7_lane7", {31'h0, bus1.y[7]}, 32'h0);
    // back-to-back changes
    step("b2b_a", 1'b0, 1'b1, 3'd2, 4'hF, 3'd2);
    step("b2b_b", 1'b0, 1'b1, 3'd5, 4'h5, 3'd5);
    step("b2b_c", 1'b0, 1'b0, 3'd5, 4'h0, 3'd5);
    // reset mid-stream
    step("mid_a", 1'b0, 1'b1, 3'd6, 4'hC, 3'd6);
    chk("mid_lit", {24'h0, bus1.y}, 32'h40);
    step("mid_r", 1'b1, 1'b1, 3'd6, 4'hC, 3'd6);
    step("mid_b", 1'b0, 1'b1, 3'd6, 4'hC, 3'd6);
    // random traffic
    for (int n = 0; n < 60; n++) begin
      step($sformatf("rnd%0d", n), ($urandom_range(0, 9) == 0),
           1'($urandom), 3'($urandom), 4'($urandom), 3'($urandom));
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
